// File: rtl/control_unit_pkg.sv
// Shared opcode and ALU function constants plus the packed control word
// that travels from the decode table to the output register.
package control_unit_pkg;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_MOV   = 5'd1;
    localparam logic [4:0] OP_MOVI  = 5'd2;
    localparam logic [4:0] OP_LOAD  = 5'd3;
    localparam logic [4:0] OP_STORE = 5'd4;
    localparam logic [4:0] OP_ADD   = 5'd5;
    localparam logic [4:0] OP_SUB   = 5'd6;
    localparam logic [4:0] OP_AND   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_XOR   = 5'd9;
    localparam logic [4:0] OP_ADDI  = 5'd10;
    localparam logic [4:0] OP_SUBI  = 5'd11;
    localparam logic [4:0] OP_CMP   = 5'd12;
    localparam logic [4:0] OP_JMP   = 5'd13;
    localparam logic [4:0] OP_JZ    = 5'd14;
    localparam logic [4:0] OP_JNZ   = 5'd15;
    localparam logic [4:0] OP_JL    = 5'd16;
    localparam logic [4:0] OP_JG    = 5'd17;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    typedef struct packed {
        logic       reg_write;
        logic       is_move;
        logic       is_mem_access;
        logic       is_imm;
        logic [2:0] alu_function;
        logic       flags_write;
        logic       dm_write_enable;
        logic       is_jz;
        logic       is_jnz;
        logic       is_jl;
        logic       is_jg;
        logic       is_jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_unit_if.sv
// Opcode in, decoded control strobes out; the master drives opcode and
// observes the controls, the slave (control_unit) does the reverse.
interface control_unit_if;

    logic [4:0] opcode;
    logic       reg_write;
    logic       is_move;
    logic       is_mem_access;
    logic       is_imm;
    logic [2:0] alu_function;
    logic       flags_write;
    logic       dm_write_enable;
    logic       is_jz;
    logic       is_jnz;
    logic       is_jl;
    logic       is_jg;
    logic       is_jump;

    modport master (
        output opcode,
        input  reg_write, is_move, is_mem_access, is_imm, alu_function,
        input  flags_write, dm_write_enable,
        input  is_jz, is_jnz, is_jl, is_jg, is_jump
    );

    modport slave (
        input  opcode,
        output reg_write, is_move, is_mem_access, is_imm, alu_function,
        output flags_write, dm_write_enable,
        output is_jz, is_jnz, is_jl, is_jg, is_jump
    );

endinterface

// File: rtl/control_decode.sv
// Purely combinational opcode-to-controls table; unlisted opcodes behave
// as NOP so the jump, move and store exclusivity holds by construction.
module control_decode
    import control_unit_pkg::*;
(
    input  logic [4:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: defaulting the whole word first keeps every path fully assigned, so no latch is inferred.
        ctrl = CTRL_NOP;
        case (opcode)
            OP_MOV: begin
                ctrl.reg_write = 1'b1;
                ctrl.is_move   = 1'b1;
            end
            OP_MOVI: begin
                ctrl.reg_write = 1'b1;
                ctrl.is_move   = 1'b1;
                ctrl.is_imm    = 1'b1;
            end
            OP_LOAD: begin
                ctrl.reg_write     = 1'b1;
                ctrl.is_mem_access = 1'b1;
                ctrl.is_imm        = 1'b1;
                ctrl.alu_function  = ALU_ADD;
            end
            OP_STORE: begin
                ctrl.is_mem_access   = 1'b1;
                ctrl.dm_write_enable = 1'b1;
                ctrl.is_imm          = 1'b1;
                ctrl.alu_function    = ALU_ADD;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                ctrl.reg_write   = 1'b1;
                ctrl.flags_write = 1'b1;
                case (opcode)
                    OP_SUB:  ctrl.alu_function = ALU_SUB;
                    OP_AND:  ctrl.alu_function = ALU_AND;
                    OP_OR:   ctrl.alu_function = ALU_OR;
                    OP_XOR:  ctrl.alu_function = ALU_XOR;
                    default: ctrl.alu_function = ALU_ADD;
                endcase
            end
            OP_ADDI, OP_SUBI: begin
                ctrl.reg_write    = 1'b1;
                ctrl.flags_write  = 1'b1;
                ctrl.is_imm       = 1'b1;
                ctrl.alu_function = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
            end
            OP_CMP: begin
                ctrl.flags_write  = 1'b1;
                ctrl.alu_function = ALU_SUB;
            end
            OP_JMP:  ctrl.is_jump = 1'b1;
            OP_JZ:   ctrl.is_jz   = 1'b1;
            OP_JNZ:  ctrl.is_jnz  = 1'b1;
            OP_JL:   ctrl.is_jl   = 1'b1;
            OP_JG:   ctrl.is_jg   = 1'b1;
            default: ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Registered instruction decoder: every control output is the decode of the
// opcode captured on the previous rising edge, cleared asynchronously by rst_n.
module control_unit
    import control_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    control_unit_if.slave bus
);

    ctrl_t dec_ctrl;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opcode (bus.opcode),
        .ctrl   (dec_ctrl)
    );

    always_comb begin
        ctrl_d = dec_ctrl;
    end

    // NOTE: the async clear is what drops the outputs mid-cycle; sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.reg_write       = ctrl_q.reg_write;
    assign bus.is_move         = ctrl_q.is_move;
    assign bus.is_mem_access   = ctrl_q.is_mem_access;
    assign bus.is_imm          = ctrl_q.is_imm;
    assign bus.alu_function    = ctrl_q.alu_function;
    assign bus.flags_write     = ctrl_q.flags_write;
    assign bus.dm_write_enable = ctrl_q.dm_write_enable;
    assign bus.is_jz           = ctrl_q.is_jz;
    assign bus.is_jnz          = ctrl_q.is_jnz;
    assign bus.is_jl           = ctrl_q.is_jl;
    assign bus.is_jg           = ctrl_q.is_jg;
    assign bus.is_jump         = ctrl_q.is_jump;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver queues hand-written expected
// control words, the monitor compares them one cycle after each opcode.
module tb_control_unit;

    // Vector order: rw mv mem imm alu[2:0] fw dwe jz jnz jl jg jmp
    typedef struct {
        logic [4:0]  op;
        logic [13:0] exp;
    } item_t;

    localparam logic [13:0] V_ZERO = 14'b0000_000_0_0_00000;
    localparam logic [13:0] V_MOVI = 14'b1101_000_0_0_00000;
    localparam logic [13:0] V_ADD  = 14'b1000_000_1_0_00000;
    localparam logic [13:0] V_AND  = 14'b1000_010_1_0_00000;
    localparam logic [13:0] V_XOR  = 14'b1000_100_1_0_00000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    item_t exp_q[$];

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] sample();
        return {bus.reg_write, bus.is_move, bus.is_mem_access, bus.is_imm,
                bus.alu_function, bus.flags_write, bus.dm_write_enable,
                bus.is_jz, bus.is_jnz, bus.is_jl, bus.is_jg, bus.is_jump};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input logic [4:0] op, input logic [13:0] exp);
        item_t it;
        @(negedge clk);
        bus.opcode = op;
        it.op  = op;
        it.exp = exp;
        exp_q.push_back(it);
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare one queued expectation per rising edge, plus invariants.
    initial begin
        item_t it;
        logic [13:0] v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                v  = sample();
                check($sformatf("op%0d", it.op), v, it.exp);
                check("jump_onehot", 14'($countones(v[4:0]) <= 1), 14'd1);
                check("dwe_rule", 14'(!v[5] || (v[11] && !v[13])), 14'd1);
                check("move_mem_excl", 14'(!(v[12] && v[11])), 14'd1);
                check("alu_range", 14'(v[9:7] <= 3'd4), 14'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.opcode = 5'd5;

        // Reset held with ADD presented: outputs stay clear across edges.
        repeat (3) @(negedge clk);
        check("reset_hold", sample(), V_ZERO);
        rst_n = 1'b1;
        exp_q.push_back('{op: 5'd5, exp: V_ADD});
        drain();

        // Back-to-back sweep of every defined opcode, then NOP aliases.
        apply(5'd0,  V_ZERO);
        apply(5'd1,  14'b1100_000_0_0_00000);
        apply(5'd2,  V_MOVI);
        apply(5'd3,  14'b1011_000_0_0_00000);
        apply(5'd4,  14'b0011_000_0_1_00000);
        apply(5'd5,  V_ADD);
        apply(5'd6,  14'b1000_001_1_0_00000);
        apply(5'd7,  V_AND);
        apply(5'd8,  14'b1000_011_1_0_00000);
        apply(5'd9,  V_XOR);
        apply(5'd10, 14'b1001_000_1_0_00000);
        apply(5'd11, 14'b1001_001_1_0_00000);
        apply(5'd12, 14'b0000_001_1_0_00000);
        apply(5'd13, 14'b0000_000_0_0_00001);
        apply(5'd14, 14'b0000_000_0_0_10000);
        apply(5'd15, 14'b0000_000_0_0_01000);
        apply(5'd16, 14'b0000_000_0_0_00100);
        apply(5'd17, 14'b0000_000_0_0_00010);
        apply(5'd18, V_ZERO);
        apply(5'd9,  V_XOR);
        apply(5'd25, V_ZERO);
        apply(5'd4,  14'b0011_000_0_1_00000);
        apply(5'd31, V_ZERO);
        drain();

        // Async reset pulse between edges with MOVI settled.
        apply(5'd2, V_MOVI);
        drain();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", sample(), V_ZERO);
        @(posedge clk);
        #1;
        check("reset_over_edge", sample(), V_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{op: 5'd2, exp: V_MOVI});
        drain();

        // Opcode change mid-cycle must not disturb outputs before the edge.
        apply(5'd7, V_AND);
        @(posedge clk);
        #2;
        bus.opcode = 5'd9;
        @(negedge clk);
        check("midcycle_stable", sample(), V_AND);
        exp_q.push_back('{op: 5'd9, exp: V_XOR});
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port opcode, input, 5 bits: instruction opcode.
REQ-005 Port reg_write, output, 1 bit: register file write enable.
REQ-006 Port is_move, output, 1 bit: writeback source is the move path, bypassing the ALU.
REQ-007 Port is_mem_access, output, 1 bit: data memory access (load or store).
REQ-008 Port is_imm, output, 1 bit: second operand is the immediate field.
REQ-009 Port alu_function, output, 3 bits: ALU operation select.
REQ-010 Port flags_write, output, 1 bit: update the Z/N/G flag register.
REQ-011 Port dm_write_enable, output, 1 bit: data memory write strobe.
REQ-012 Ports is_jz, is_jnz, is_jl and is_jg, outputs, 1 bit each: conditional jump on zero, not-zero, less and greater respectively.
REQ-013 Port is_jump, output, 1 bit: unconditional jump.

Function
REQ-014 All outputs SHALL be registered and SHALL present the decode of the opcode sampled at the previous rising clk edge (1-cycle latency); there is no combinational path from opcode to any output.
REQ-015 alu_function encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; 101-111 unused and never driven.
REQ-016 The decode table SHALL be as follows; any output not listed for an opcode is 0 and alu_function is 000:
- 0 NOP: none
- 1 MOV: reg_write, is_move
- 2 MOVI: reg_write, is_move, is_imm
- 3 LOAD: reg_write, is_mem_access, is_imm (address = base + imm, ALU ADD)
- 4 STORE: is_mem_access, dm_write_enable, is_imm (ALU ADD)
- 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR: reg_write, flags_write; alu = 000, 001, 010, 011, 100 respectively
- 10 ADDI, 11 SUBI: reg_write, flags_write, is_imm; alu = 000 and 001 respectively
- 12 CMP: flags_write, alu 001 (no reg_write)
- 13 JMP: is_jump
- 14 JZ: is_jz
- 15 JNZ: is_jnz
- 16 JL: is_jl
- 17 JG: is_jg
REQ-017 Opcodes 18-31 SHALL decode exactly as NOP (all outputs 0).
REQ-018 At most one of is_jump, is_jz, is_jnz, is_jl and is_jg SHALL be 1 in any cycle.
REQ-019 dm_write_enable SHALL be 1 only when is_mem_access is 1 and reg_write is 0.
REQ-020 is_move and is_mem_access SHALL never both be 1.
REQ-021 An opcode change between edges SHALL have no effect until the next rising edge; back-to-back distinct opcodes SHALL each be reflected for exactly one cycle.

Reset
REQ-022 While rst_n is 0, all outputs SHALL be 0 (NOP state) immediately, independent of clk.
REQ-023 On rst_n deassertion, the first rising clk edge SHALL load the decode of the current opcode.
REQ-024 Reset asserted mid-stream SHALL force all outputs to 0 without waiting for a clock edge, overriding any pending decode.

Structure
REQ-025 A shared package SHALL hold the 5-bit opcode constants (OP_NOP through OP_JG) and the 3-bit ALU function constants (ALU_ADD through ALU_XOR).
REQ-026 The block SHALL contain one sub-module, control_decode, a purely combinational opcode-to-controls table; control_unit SHALL instantiate it and register its outputs.

Verification
REQ-027 Hold rst_n=0 with opcode=5 -> all outputs 0; release rst_n, one edge later -> reg_write=1, flags_write=1, alu_function=000.
REQ-028 Sweep opcode 0..17, one per clock -> outputs match REQ-016 one cycle after each opcode is applied; e.g. 4 -> is_mem_access=1, dm_write_enable=1, is_imm=1.
REQ-029 Opcodes 18, 25 and 31 -> all outputs 0.
REQ-030 opcode=12 -> flags_write=1, alu_function=001, reg_write=0; opcode=13..17 -> exactly one jump output high each cycle.
REQ-031 With opcode=2 and outputs settled, pulse rst_n low between clock edges -> outputs drop to 0 asynchronously, then return to MOVI decode on the first edge after release.
REQ-032 Change opcode mid-cycle -> outputs stay stable until the next rising edge.
